// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one Rsa256Core between N_REQ requesters.
// Define RSA_ARB_TIMEOUT_EN to add the S_WAIT watchdog and o_timeout.
module rsa_core_arbiter #(
    parameter int WIDTH = 256,
    parameter int N_REQ = 2
`ifdef RSA_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_d,
    input  logic [N_REQ*WIDTH-1:0] i_n,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_core_start,
    output logic [WIDTH-1:0]       o_core_a,
    output logic [WIDTH-1:0]       o_core_d,
    output logic [WIDTH-1:0]       o_core_n,
    input  logic [WIDTH-1:0]       i_core_result,
    input  logic                   i_core_finished
`ifdef RSA_ARB_TIMEOUT_EN
    ,
    output logic                   o_timeout
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_rr;
    logic [PW-1:0]      r_owner;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_start;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_n;

    logic               w_any;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_next_rr;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]      r_cnt;
    logic               r_to;
`endif

    // r_rr and r_owner stay below N_REQ, so one subtraction wraps any sum.
    function automatic logic [PW-1:0] wrap(input int v);
        return (v >= N_REQ) ? PW'(v - N_REQ) : PW'(v);
    endfunction

    // Scan downward so the lowest offset from r_rr is the last to win.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[wrap(int'(r_rr) + k)]) begin
                w_any = 1'b1;
                w_win = wrap(int'(r_rr) + k);
            end
        end
    end

    assign w_next_rr = wrap(int'(r_owner) + 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rr     <= '0;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_a      <= '0;
            r_d      <= '0;
            r_n      <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_to     <= 1'b0;
`endif
        end else begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_win;
                        r_a          <= i_a[int'(w_win)*WIDTH +: WIDTH];
                        r_d          <= i_d[int'(w_win)*WIDTH +: WIDTH];
                        r_n          <= i_n[int'(w_win)*WIDTH +: WIDTH];
                        r_gnt[w_win] <= 1'b1;
                        r_start      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
`ifdef RSA_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_core_finished) begin
                        r_result        <= i_core_result;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_DONE;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_result        <= '0;
                        r_done[r_owner] <= 1'b1;
                        r_to            <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_rr    <= w_next_rr;
                    r_busy  <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
                    r_to    <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_done       = r_done;
    assign o_result     = r_result;
    assign o_busy       = r_busy;
    assign o_core_start = r_start;
    assign o_core_a     = r_a;
    assign o_core_d     = r_d;
    assign o_core_n     = r_n;
`ifdef RSA_ARB_TIMEOUT_EN
    assign o_timeout    = r_to;
`endif

endmodule

// File: doc/rsa_core_arbiter.md
Name: rsa_core_arbiter

Overview:
- Shares one Rsa256Core modular-exponentiation datapath between N_REQ independent requesters, e.g. several UART/Avalon wrappers or a self-test engine.
- Performs round-robin arbitration and latches the winner's operands.
- Sequences the core's start/finished handshake.
- Routes the result back to the owning requester with a one-cycle done pulse.
- Sits between the requester-side wrappers and a single core instance.

Parameters:
- WIDTH, 256, operand/result width in bits (a, d, n, result).
- N_REQ, 2, number of requesters; legal range 1..4.
- TIMEOUT_CYCLES, 1048576, watchdog limit in S_WAIT; used only with RSA_ARB_TIMEOUT_EN.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  per-requester request level.
- i_a  input  N_REQ*WIDTH  base operands; requester k occupies bits [k*WIDTH +: WIDTH].
- i_d  input  N_REQ*WIDTH  exponents; same packing as i_a.
- i_n  input  N_REQ*WIDTH  moduli; same packing as i_a.
- o_gnt  output  N_REQ  one-cycle grant pulse; operands captured.
- o_done  output  N_REQ  one-cycle completion pulse to the owner.
- o_result  output  WIDTH  result; valid while o_done is high, held until the next completion.
- o_busy  output  1  high whenever state != S_IDLE.
- o_core_start  output  1  one-cycle start pulse to the core.
- o_core_a, o_core_d, o_core_n  output  WIDTH each  latched operands to the core.
- i_core_result  input  WIDTH  core result.
- i_core_finished  input  1  core completion pulse.
- o_timeout  output  1  only with RSA_ARB_TIMEOUT_EN.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=S_IDLE, rr_ptr=0, owner=0.
  - All outputs 0: o_gnt, o_done, o_result, o_busy, o_core_start, core operand registers, o_timeout.
- All outputs are registered.
- S_IDLE:
  - If any i_req bit is high, the winner is the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At that edge: latch the winner's a/d/n into the core operand registers, owner<=winner, state<=S_START.
- S_START (exactly 1 cycle):
  - o_gnt[owner]=1 and o_core_start=1 in the same cycle.
  - i_core_finished is ignored in this state.
  - Next state: S_WAIT.
- S_WAIT:
  - Core operand outputs held stable.
  - When i_core_finished=1: o_result<=i_core_result, state<=S_DONE.
- S_DONE (exactly 1 cycle):
  - o_done[owner]=1.
  - rr_ptr<=(owner+1) mod N_REQ.
  - state<=S_IDLE.
- Latency:
  - Request sampled in S_IDLE at edge t gives o_gnt at cycle t+1.
  - i_core_finished sampled at edge m gives o_done at cycle m+1.
  - Earliest next grant is at cycle m+3.
- Operands are sampled only at the grant edge; requesters may change them after o_gnt.
- A requester holding i_req high after its grant is treated as a new request; because of round-robin it is served after any other pending requester.
- A request deasserted before it is granted is simply never served; there is no internal queue.
- i_core_finished outside S_WAIT is ignored.
- N_REQ=1: rr_ptr stays 0; behaviour is otherwise identical.
- Reset mid-operation:
  - Everything aborts immediately and no o_done is issued.
  - The core must be reset in the same reset domain; the top level inverts i_rst_n for the core's active-high i_rst.
- Only one o_gnt bit and one o_done bit may be high in any cycle; o_gnt and o_done are never high in the same cycle.

Optional Feature:
- Macro: RSA_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to S_WAIT and increments each S_WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no i_core_finished: go to S_DONE with o_result<=0 and o_timeout=1 for the same cycle as o_done.
  - The next grant re-pulses o_core_start, and the core must restart on it.
  - i_core_finished on the same edge as the limit counts as finished, not a timeout.
- Undefined:
  - No counter and no o_timeout port.
  - S_WAIT waits indefinitely.

Test Plan:
- Reset: hold i_rst_n=0 with i_req=2'b11 → all outputs 0, no o_core_start; after release the first grant goes to requester 0.
- Single request: req0 with a=5, d=3, n=13 → o_gnt[0] and o_core_start together one cycle after the request; o_done[0] one cycle after i_core_finished with o_result=8; o_busy low afterwards.
- Contention: req0 (a=2, d=10, n=1000) and req1 (a=3, d=4, n=7) raised together → requester 0 served first, result 24; requester 1 served next, result 4; o_done pulses are on separate cycles and routed correctly.
- Fairness: both requests held high for 6 jobs → grant order is 0,1,0,1,0,1.
- Abort: deassert i_rst_n mid S_WAIT → outputs clear asynchronously, no o_done; a fresh req1 after release completes normally.
- With RSA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: core model never finishes → o_done[owner]=1, o_timeout=1, o_result=0 after 16 S_WAIT cycles; the next request is granted normally.
